mem_ctrl_multi: RTL and testbench
=================================

Name: mem_ctrl_multi

Overview:
Parametrised byte-serial memory controller. Arbitrates NUM_CH requesters (fetcher, LSB load port, ROB store port, future prefetch/DMA) onto the single 8-bit synchronous RAM port. It serialises 1/2/4-byte reads and writes and returns tagged, optionally sign-extended responses. It replaces the fixed three-client controller and sits between the fetch/LSB/ROB layer and the RAM/IO bus.

Parameters:
XLEN, 32, data/address width
NUM_CH, 3, number of requester channels (1..8)
TAG_W, 4, width of per-request tag (ROB id etc.)
CH_W, 2, width of channel index, >= clog2(NUM_CH)

Ports:
clk  in  1  clock
rst  in  1  synchronous reset, active-high
rdy  in  1  global clock enable; low freezes all state
flush  in  1  mispredict flush
ch_req  in  NUM_CH  request valid per channel
ch_gnt  out  NUM_CH  one-hot accept, combinational
ch_we  in  NUM_CH  1 = store
ch_size  in  2*NUM_CH  0 byte, 1 half, 2 word, 3 treated as word
ch_signed  in  NUM_CH  sign-extend load result
ch_addr  in  XLEN*NUM_CH  byte address
ch_wdata  in  XLEN*NUM_CH  store data, little-endian
ch_tag  in  TAG_W*NUM_CH  returned with response
rsp_valid  out  1  one-cycle response pulse
rsp_ch  out  CH_W  channel of response
rsp_tag  out  TAG_W  tag of response
rsp_we  out  1  response is store completion
rsp_data  out  XLEN  load data (0 for stores)
busy  out  1  transfer in progress
ram_din  in  8  RAM read data, valid the cycle after address
ram_dout  out  8  RAM write data
ram_a  out  XLEN  RAM address
ram_wr  out  1  RAM write enable

Behaviour:
- Reset is synchronous, active-high on clk (rst). All outputs reset to 0, state IDLE, round-robin pointer 0. rst has priority over rdy=0? No: rst acts only when rdy=1, as elsewhere in the codebase.
- rdy=0: no state or output changes; ch_gnt forced 0.
- States: IDLE, READ, WRITE. Counter k (0..3) tracks the byte index; n = bytes for the latched size.
- ch_gnt[i] = rdy & !flush & state==IDLE & winner==i. Transfer happens at edge E0 where ch_req[i] & ch_gnt[i]. Requester holds the request until gnt is seen.
- Winner is the lowest-index channel with ch_req set (fixed priority).
- At E0 the controller latches addr/wdata/size/signed/tag/ch and drives ram_a=addr.
  - Store: ram_wr=1, ram_dout=wdata[7:0], go to WRITE.
  - Load: ram_wr=0, go to READ.
- READ: at edge E_k (k=1..n), capture ram_din as byte k-1. For k<n, drive ram_a=addr+k. At E_n: rsp_valid=1, rsp_we=0, rsp_data=assembled value (zero-extended, or sign-extended from bit 8n-1 if signed), ram_a=0, state IDLE. Load latency is E0 to rsp_valid high after E_n, i.e. n+1 cycles of occupancy.
- WRITE: at E_k for k<n, drive ram_a=addr+k and ram_dout=wdata[8k+7:8k], keeping ram_wr=1. At E_n: ram_wr=0, ram_a=0, rsp_valid=1, rsp_we=1, rsp_data=0, state IDLE.
- rsp_valid is high for exactly one cycle; rsp_ch/rsp_tag hold until the next response.
- Address arithmetic is modulo 2^XLEN; addr=FFFFFFFF word access wraps to 0..2. Misalignment is permitted.
- busy = (state!=IDLE).
- flush:
  - In READ: abort immediately, no rsp_valid, ram_a=0, return to IDLE.
  - In WRITE: ignored; the store completes all bytes and reports completion (committed stores must not be lost).
  - In IDLE: no grant that cycle.
- Simultaneous flush and rsp edge (E_n of a read): response suppressed.
- Earliest next grant is the cycle after E_n; there is no back-to-back overlap.

Optional Feature:
MEM_RR_ARB_EN
- Defined: round-robin arbitration. Search starts at the channel after the last granted one (pointer updates at each accept, wraps NUM_CH-1 to 0). This prevents fetch starvation under continuous LSB traffic.
- Undefined: fixed lowest-index priority; no pointer register.

Test Plan:
- LW, ch1, addr 0x100, RAM bytes 11,22,33,44 -> ram_a 100,101,102,103 on consecutive cycles. rsp_valid 5 cycles after accept, rsp_data 0x44332211, rsp_ch 1, tag echoed.
- LB signed at 0x20 holding 0x80 -> rsp_data 0xFFFFFF80. The same access with LBU -> 0x00000080.
- SH ch2, addr 0x200, wdata 0xBEEF -> ram_wr=1 with (200,EF) then (201,BE), ram_wr 0 afterwards, rsp_we=1.
- ch0 and ch1 requesting continuously, 4 grants -> fixed priority: 0,0,0,0. With MEM_RR_ARB_EN: 0,1,0,1.
- flush during a LW after byte 1 -> no rsp_valid, IDLE next cycle. flush during an SW at byte 1 -> all 4 bytes written, rsp_we pulse.
- LW at 0xFFFFFFFF -> addresses FFFFFFFF,0,1,2. rdy low for 3 cycles mid-read -> addresses and result unchanged, completion delayed by 3 cycles.

Source files
------------

// File: rtl/mem_ctrl_multi.sv
// Byte-serial memory controller: arbitrates NUM_CH requesters onto one 8-bit RAM port.
// Optional MEM_RR_ARB_EN selects round-robin arbitration instead of fixed priority.
module mem_ctrl_multi #(
  parameter int XLEN   = 32,
  parameter int NUM_CH = 3,
  parameter int TAG_W  = 4,
  parameter int CH_W   = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    rdy,
  input  logic                    flush,
  input  logic [NUM_CH-1:0]       ch_req,
  output logic [NUM_CH-1:0]       ch_gnt,
  input  logic [NUM_CH-1:0]       ch_we,
  input  logic [2*NUM_CH-1:0]     ch_size,
  input  logic [NUM_CH-1:0]       ch_signed,
  input  logic [XLEN*NUM_CH-1:0]  ch_addr,
  input  logic [XLEN*NUM_CH-1:0]  ch_wdata,
  input  logic [TAG_W*NUM_CH-1:0] ch_tag,
  output logic                    rsp_valid,
  output logic [CH_W-1:0]         rsp_ch,
  output logic [TAG_W-1:0]        rsp_tag,
  output logic                    rsp_we,
  output logic [XLEN-1:0]         rsp_data,
  output logic                    busy,
  input  logic [7:0]              ram_din,
  output logic [7:0]              ram_dout,
  output logic [XLEN-1:0]         ram_a,
  output logic                    ram_wr
);

  typedef enum logic [1:0] {IDLE, READ, WRITE} state_t;

  state_t           state, state_n;
  logic [1:0]       idx, idx_n;
  logic [1:0]       idx_plus;
  logic [XLEN-1:0]  addr_q, addr_n;
  logic [XLEN-1:0]  wdata_q, wdata_n;
  logic [XLEN-1:0]  data_q, data_n;
  logic [1:0]       size_q, size_n;
  logic             signed_q, signed_n;
  logic [CH_W-1:0]  ch_q, ch_n;
  logic [TAG_W-1:0] tag_q, tag_n;

  logic [XLEN-1:0]  ram_a_n;
  logic [7:0]       ram_dout_n;
  logic             ram_wr_n;
  logic             rsp_valid_n;
  logic [CH_W-1:0]  rsp_ch_n;
  logic [TAG_W-1:0] rsp_tag_n;
  logic             rsp_we_n;
  logic [XLEN-1:0]  rsp_data_n;

  logic [CH_W-1:0]  winner;
  logic             any_req;
  logic             accept;
  logic [1:0]       last;
  logic [XLEN-1:0]  assembled;
  logic [XLEN-1:0]  extended;

  function automatic logic [1:0] last_idx(input logic [1:0] s);
    case (s)
      2'd0:    return 2'd0;
      2'd1:    return 2'd1;
      default: return 2'd3;
    endcase
  endfunction

`ifdef MEM_RR_ARB_EN
  // rr_ptr is where the next search starts: one past the last accepted channel.
  logic [CH_W-1:0] rr_ptr, rr_ptr_n;
  int              c;

  always_comb begin
    winner  = '0;
    any_req = 1'b0;
    c       = 0;
    for (int j = 0; j < NUM_CH; j++) begin
      c = int'(rr_ptr) + j;
      if (c >= NUM_CH) c = c - NUM_CH;
      if (!any_req && ch_req[c]) begin
        winner  = CH_W'(c);
        any_req = 1'b1;
      end
    end
  end

  always_comb begin
    rr_ptr_n = rr_ptr;
    if (accept) rr_ptr_n = (int'(winner) == NUM_CH - 1) ? '0 : winner + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rdy) begin
      if (rst) rr_ptr <= '0;
      else     rr_ptr <= rr_ptr_n;
    end
  end
`else
  always_comb begin
    winner  = '0;
    any_req = |ch_req;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (ch_req[i]) winner = CH_W'(i);
    end
  end
`endif

  always_comb begin
    ch_gnt = '0;
    if (rdy && !flush && state == IDLE && any_req) ch_gnt[winner] = 1'b1;
  end

  assign accept   = |(ch_req & ch_gnt);
  assign busy     = (state != IDLE);
  assign last     = last_idx(size_q);
  assign idx_plus = idx + 2'd1;

  // Partial load value with the byte arriving this cycle merged in, then extended.
  always_comb begin
    assembled = data_q;
    assembled[{idx, 3'b000} +: 8] = ram_din;
    case (size_q)
      2'd0:    extended = signed_q ? {{(XLEN-8){assembled[7]}}, assembled[7:0]}
                                   : {{(XLEN-8){1'b0}}, assembled[7:0]};
      2'd1:    extended = signed_q ? {{(XLEN-16){assembled[15]}}, assembled[15:0]}
                                   : {{(XLEN-16){1'b0}}, assembled[15:0]};
      default: extended = assembled;
    endcase
  end

  always_comb begin
    state_n     = state;
    idx_n       = idx;
    addr_n      = addr_q;
    wdata_n     = wdata_q;
    data_n      = data_q;
    size_n      = size_q;
    signed_n    = signed_q;
    ch_n        = ch_q;
    tag_n       = tag_q;
    ram_a_n     = ram_a;
    ram_dout_n  = ram_dout;
    ram_wr_n    = ram_wr;
    rsp_valid_n = 1'b0;
    rsp_ch_n    = rsp_ch;
    rsp_tag_n   = rsp_tag;
    rsp_we_n    = rsp_we;
    rsp_data_n  = rsp_data;

    case (state)
      IDLE: begin
        if (accept) begin
          addr_n   = ch_addr[winner*XLEN +: XLEN];
          wdata_n  = ch_wdata[winner*XLEN +: XLEN];
          size_n   = ch_size[winner*2 +: 2];
          signed_n = ch_signed[winner];
          tag_n    = ch_tag[winner*TAG_W +: TAG_W];
          ch_n     = winner;
          idx_n    = 2'd0;
          data_n   = '0;
          ram_a_n  = ch_addr[winner*XLEN +: XLEN];
          if (ch_we[winner]) begin
            ram_wr_n   = 1'b1;
            ram_dout_n = ch_wdata[winner*XLEN +: 8];
            state_n    = WRITE;
          end else begin
            ram_wr_n = 1'b0;
            state_n  = READ;
          end
        end
      end

      READ: begin
        if (flush) begin
          ram_a_n = '0;
          state_n = IDLE;
        end else begin
          data_n = assembled;
          if (idx == last) begin
            rsp_valid_n = 1'b1;
            rsp_we_n    = 1'b0;
            rsp_data_n  = extended;
            rsp_ch_n    = ch_q;
            rsp_tag_n   = tag_q;
            ram_a_n     = '0;
            state_n     = IDLE;
          end else begin
            ram_a_n = addr_q + XLEN'(idx_plus);
            idx_n   = idx_plus;
          end
        end
      end

      // Committed stores finish even under flush.
      WRITE: begin
        if (idx == last) begin
          ram_wr_n    = 1'b0;
          ram_a_n     = '0;
          rsp_valid_n = 1'b1;
          rsp_we_n    = 1'b1;
          rsp_data_n  = '0;
          rsp_ch_n    = ch_q;
          rsp_tag_n   = tag_q;
          state_n     = IDLE;
        end else begin
          ram_a_n    = addr_q + XLEN'(idx_plus);
          ram_dout_n = wdata_q[{idx_plus, 3'b000} +: 8];
          ram_wr_n   = 1'b1;
          idx_n      = idx_plus;
        end
      end

      default: state_n = IDLE;
    endcase
  end

  // rdy gates everything, including reset.
  always_ff @(posedge clk) begin
    if (rdy) begin
      if (rst) begin
        state     <= IDLE;
        idx       <= '0;
        addr_q    <= '0;
        wdata_q   <= '0;
        data_q    <= '0;
        size_q    <= '0;
        signed_q  <= 1'b0;
        ch_q      <= '0;
        tag_q     <= '0;
        ram_a     <= '0;
        ram_dout  <= '0;
        ram_wr    <= 1'b0;
        rsp_valid <= 1'b0;
        rsp_ch    <= '0;
        rsp_tag   <= '0;
        rsp_we    <= 1'b0;
        rsp_data  <= '0;
      end else begin
        state     <= state_n;
        idx       <= idx_n;
        addr_q    <= addr_n;
        wdata_q   <= wdata_n;
        data_q    <= data_n;
        size_q    <= size_n;
        signed_q  <= signed_n;
        ch_q      <= ch_n;
        tag_q     <= tag_n;
        ram_a     <= ram_a_n;
        ram_dout  <= ram_dout_n;
        ram_wr    <= ram_wr_n;
        rsp_valid <= rsp_valid_n;
        rsp_ch    <= rsp_ch_n;
        rsp_tag   <= rsp_tag_n;
        rsp_we    <= rsp_we_n;
        rsp_data  <= rsp_data_n;
      end
    end
  end

endmodule

// File: tb/tb_mem_ctrl_multi.sv
// Self-checking bench for mem_ctrl_multi: vector table of single transactions plus
// hand-written sequences for arbitration, flush, address wrap and rdy stalls.
module tb_mem_ctrl_multi;

  logic        clk = 1'b0;
  logic        rst;
  logic        rdy;
  logic        flush;
  logic [2:0]  ch_req;
  logic [2:0]  ch_gnt;
  logic [2:0]  ch_we;
  logic [5:0]  ch_size;
  logic [2:0]  ch_signed;
  logic [95:0] ch_addr;
  logic [95:0] ch_wdata;
  logic [11:0] ch_tag;
  logic        rsp_valid;
  logic [1:0]  rsp_ch;
  logic [3:0]  rsp_tag;
  logic        rsp_we;
  logic [31:0] rsp_data;
  logic        busy;
  logic [7:0]  ram_din;
  logic [7:0]  ram_dout;
  logic [31:0] ram_a;
  logic        ram_wr;

  mem_ctrl_multi #(.XLEN(32), .NUM_CH(3), .TAG_W(4), .CH_W(2)) dut (
    .clk(clk), .rst(rst), .rdy(rdy), .flush(flush),
    .ch_req(ch_req), .ch_gnt(ch_gnt), .ch_we(ch_we), .ch_size(ch_size),
    .ch_signed(ch_signed), .ch_addr(ch_addr), .ch_wdata(ch_wdata), .ch_tag(ch_tag),
    .rsp_valid(rsp_valid), .rsp_ch(rsp_ch), .rsp_tag(rsp_tag), .rsp_we(rsp_we),
    .rsp_data(rsp_data), .busy(busy), .ram_din(ram_din), .ram_dout(ram_dout),
    .ram_a(ram_a), .ram_wr(ram_wr)
  );

  always #5 clk = ~clk;

  // Read-only RAM image (1 KiB alias window) and a log of every write the DUT issues.
  logic [7:0]  mem [0:1023];
  assign ram_din = mem[ram_a[9:0]];

  logic [31:0] wa [0:63];
  logic [7:0]  wd [0:63];
  int          wr_cnt  = 0;
  int          rsp_cnt = 0;

  always @(posedge clk) begin
    if (rdy && ram_wr && wr_cnt < 64) begin
      wa[wr_cnt] <= ram_a;
      wd[wr_cnt] <= ram_dout;
      wr_cnt     <= wr_cnt + 1;
    end
  end

  always @(negedge clk) begin
    if (rsp_valid === 1'b1) rsp_cnt <= rsp_cnt + 1;
  end

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = 8'h00;
    mem[10'h100] = 8'h11; mem[10'h101] = 8'h22; mem[10'h102] = 8'h33; mem[10'h103] = 8'h44;
    mem[10'h020] = 8'h80;
    mem[10'h030] = 8'h34; mem[10'h031] = 8'hF2;
    mem[10'h040] = 8'h7F;
    mem[10'h3FF] = 8'hAA; mem[10'h000] = 8'hBB; mem[10'h001] = 8'hCC; mem[10'h002] = 8'hDD;
  end

  typedef struct {
    logic        we;
    logic [1:0]  size;
    logic        sgn;
    int          ch;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  tag;
    logic [31:0] exp_data;
  } vec_t;

  vec_t vecs [10];
  int   n_checks = 0;
  int   n_pass   = 0;

  function automatic int bytesOf(input logic [1:0] s);
    return (s == 2'd0) ? 1 : ((s == 2'd1) ? 2 : 4);
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  task automatic setCh(input int ch, input logic we, input logic [1:0] size, input logic sgn,
                       input logic [31:0] addr, input logic [31:0] wdata, input logic [3:0] tag);
    ch_we[ch]          = we;
    ch_size[ch*2 +: 2] = size;
    ch_signed[ch]      = sgn;
    ch_addr[ch*32 +: 32]  = addr;
    ch_wdata[ch*32 +: 32] = wdata;
    ch_tag[ch*4 +: 4]     = tag;
  endtask

  task automatic applyStimulus(input vec_t v);
    setCh(v.ch, v.we, v.size, v.sgn, v.addr, v.wdata, v.tag);
    ch_req[v.ch] = 1'b1;
  endtask

  // Returns at one time step after the accepting edge E0.
  task automatic waitGrant(input int ch, output int ok);
    ok = 0;
    for (int i = 0; i < 20 && ok == 0; i++) begin
      #1;
      if (ch_gnt[ch] === 1'b1) ok = 1;
      @(posedge clk); #1;
    end
    ch_req = '0;
    if (ok == 0) checkOutput("grant_timeout", 32'd0, 32'd1);
  endtask

  task automatic waitRsp(output int cyc);
    cyc = 0;
    while (rsp_valid !== 1'b1 && cyc < 40) begin
      @(posedge clk); #1;
      cyc++;
    end
    if (rsp_valid !== 1'b1) checkOutput("rsp_timeout", 32'd0, 32'd1);
  endtask

  task automatic resetDut();
    rst = 1'b1; rdy = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic addrSeq(input string nm, input int ch, input logic [31:0] base, input logic [31:0] exp);
    int ok;
    setCh(ch, 1'b0, 2'd2, 1'b0, base, 32'h0, 4'h1);
    ch_req[ch] = 1'b1;
    waitGrant(ch, ok);
    for (int k = 0; k < 4; k++) begin
      checkOutput($sformatf("%s_ram_a%0d", nm, k), ram_a, base + 32'(k));
      if (k == 0) checkOutput($sformatf("%s_busy", nm), 32'(busy), 32'd1);
      @(posedge clk); #1;
    end
    checkOutput($sformatf("%s_rsp_valid", nm), 32'(rsp_valid), 32'd1);
    checkOutput($sformatf("%s_data", nm), rsp_data, exp);
    checkOutput($sformatf("%s_ram_a_idle", nm), ram_a, 32'd0);
    checkOutput($sformatf("%s_busy_idle", nm), 32'(busy), 32'd0);
    @(posedge clk); #1;
  endtask

  initial begin
    int ok, cyc, wstart, rc0, cnt;
    int got [4];
    int exp_arb [4];
    vec_t v;

    vecs[0] = '{1'b0, 2'd2, 1'b0, 1, 32'h0000_0100, 32'h0, 4'h5, 32'h4433_2211};
    vecs[1] = '{1'b0, 2'd0, 1'b1, 0, 32'h0000_0020, 32'h0, 4'h3, 32'hFFFF_FF80};
    vecs[2] = '{1'b0, 2'd0, 1'b0, 0, 32'h0000_0020, 32'h0, 4'h4, 32'h0000_0080};
    vecs[3] = '{1'b0, 2'd1, 1'b1, 2, 32'h0000_0030, 32'h0, 4'h9, 32'hFFFF_F234};
    vecs[4] = '{1'b0, 2'd1, 1'b0, 2, 32'h0000_0030, 32'h0, 4'hA, 32'h0000_F234};
    vecs[5] = '{1'b0, 2'd3, 1'b1, 1, 32'h0000_0100, 32'h0, 4'hB, 32'h4433_2211};
    vecs[6] = '{1'b0, 2'd0, 1'b1, 0, 32'h0000_0040, 32'h0, 4'hC, 32'h0000_007F};
    vecs[7] = '{1'b1, 2'd1, 1'b0, 2, 32'h0000_0200, 32'h0000_BEEF, 4'h7, 32'h0};
    vecs[8] = '{1'b1, 2'd2, 1'b0, 0, 32'h0000_0300, 32'h1234_5678, 4'hD, 32'h0};
    vecs[9] = '{1'b0, 2'd2, 1'b0, 1, 32'hFFFF_FFFF, 32'h0, 4'hE, 32'hDDCC_BBAA};

    rst = 1'b1; rdy = 1'b1; flush = 1'b0;
    ch_req = '0; ch_we = '0; ch_size = '0; ch_signed = '0;
    ch_addr = '0; ch_wdata = '0; ch_tag = '0;
    resetDut();

    checkOutput("rst_ram_a", ram_a, 32'd0);
    checkOutput("rst_ram_wr", 32'(ram_wr), 32'd0);
    checkOutput("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    checkOutput("rst_rsp_data", rsp_data, 32'd0);
    checkOutput("rst_busy", 32'(busy), 32'd0);
    checkOutput("rst_gnt", 32'(ch_gnt), 32'd0);

    // Grant must be suppressed while rdy is low, and present once it returns.
    ch_req[2] = 1'b1; rdy = 1'b0; #1;
    checkOutput("gnt_rdy_low", 32'(ch_gnt), 32'd0);
    rdy = 1'b1; #1;
    checkOutput("gnt_rdy_high", 32'(ch_gnt), 32'b100);
    ch_req = '0;
    @(posedge clk); #1;

    for (int i = 0; i < 10; i++) begin
      v = vecs[i];
      wstart = wr_cnt;
      applyStimulus(v);
      waitGrant(v.ch, ok);
      waitRsp(cyc);
      checkOutput($sformatf("v%0d_data", i), rsp_data, v.exp_data);
      checkOutput($sformatf("v%0d_we", i), 32'(rsp_we), 32'(v.we));
      checkOutput($sformatf("v%0d_ch", i), 32'(rsp_ch), 32'(v.ch));
      checkOutput($sformatf("v%0d_tag", i), 32'(rsp_tag), 32'(v.tag));
      checkOutput($sformatf("v%0d_latency", i), 32'(cyc + 1), 32'(bytesOf(v.size) + 1));
      if (v.we) begin
        checkOutput($sformatf("v%0d_wr_count", i), 32'(wr_cnt - wstart), 32'(bytesOf(v.size)));
        for (int b = 0; b < bytesOf(v.size); b++) begin
          checkOutput($sformatf("v%0d_wr_a%0d", i, b), wa[wstart + b], v.addr + 32'(b));
          checkOutput($sformatf("v%0d_wr_d%0d", i, b), 32'(wd[wstart + b]), 32'(v.wdata[8*b +: 8]));
        end
        checkOutput($sformatf("v%0d_wr_off", i), 32'(ram_wr), 32'd0);
      end
      @(posedge clk); #1;
      checkOutput($sformatf("v%0d_pulse", i), 32'(rsp_valid), 32'd0);
    end

    addrSeq("lw100", 1, 32'h0000_0100, 32'h4433_2211);
    addrSeq("lwwrap", 1, 32'hFFFF_FFFF, 32'hDDCC_BBAA);

    // Arbitration with channels 0 and 1 requesting continuously, from a fresh pointer.
    resetDut();
`ifdef MEM_RR_ARB_EN
    exp_arb = '{0, 1, 0, 1};
`else
    exp_arb = '{0, 0, 0, 0};
`endif
    got = '{-1, -1, -1, -1};
    setCh(0, 1'b0, 2'd0, 1'b0, 32'h20, 32'h0, 4'h1);
    setCh(1, 1'b0, 2'd0, 1'b0, 32'h20, 32'h0, 4'h2);
    ch_req = 3'b011;
    cnt = 0;
    for (int c = 0; c < 60 && cnt < 4; c++) begin
      #1;
      if (ch_gnt != 3'b000) begin
        got[cnt] = (ch_gnt == 3'b010) ? 1 : ((ch_gnt == 3'b001) ? 0 : 9);
        cnt++;
      end
      @(posedge clk); #1;
    end
    ch_req = '0;
    waitRsp(cyc);
    @(posedge clk); #1;
    for (int g = 0; g < 4; g++) checkOutput($sformatf("arb_grant%0d", g), 32'(got[g]), 32'(exp_arb[g]));

    // Flush in IDLE blocks the grant.
    ch_req[0] = 1'b1; flush = 1'b1; #1;
    checkOutput("flush_idle_gnt", 32'(ch_gnt), 32'd0);
    @(posedge clk); #1;
    checkOutput("flush_idle_busy", 32'(busy), 32'd0);
    ch_req = '0; flush = 1'b0;

    // Flush a word load after its first byte: aborted, no response.
    rc0 = rsp_cnt;
    setCh(1, 1'b0, 2'd2, 1'b0, 32'h100, 32'h0, 4'h2);
    ch_req[1] = 1'b1;
    waitGrant(1, ok);
    @(posedge clk); #1;
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    checkOutput("flush_rd_busy", 32'(busy), 32'd0);
    checkOutput("flush_rd_ram_a", ram_a, 32'd0);
    repeat (6) @(posedge clk);
    #1 checkOutput("flush_rd_no_rsp", 32'(rsp_cnt - rc0), 32'd0);

    // Flush coinciding with the final byte edge of a byte load suppresses the response.
    rc0 = rsp_cnt;
    setCh(0, 1'b0, 2'd0, 1'b1, 32'h20, 32'h0, 4'h3);
    ch_req[0] = 1'b1;
    waitGrant(0, ok);
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    checkOutput("flush_last_busy", 32'(busy), 32'd0);
    repeat (3) @(posedge clk);
    #1 checkOutput("flush_last_no_rsp", 32'(rsp_cnt - rc0), 32'd0);

    // Flush during a word store is ignored: all bytes written, completion reported.
    wstart = wr_cnt;
    setCh(0, 1'b1, 2'd2, 1'b0, 32'h300, 32'hCAFE_F00D, 4'h6);
    ch_req[0] = 1'b1;
    waitGrant(0, ok);
    @(posedge clk); #1;
    flush = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    flush = 1'b0;
    waitRsp(cyc);
    checkOutput("flush_wr_rsp_we", 32'(rsp_we), 32'd1);
    checkOutput("flush_wr_tag", 32'(rsp_tag), 32'h6);
    checkOutput("flush_wr_count", 32'(wr_cnt - wstart), 32'd4);
    checkOutput("flush_wr_d0", 32'(wd[wstart]), 32'h0D);
    checkOutput("flush_wr_d3", 32'(wd[wstart + 3]), 32'hCA);
    checkOutput("flush_wr_a3", wa[wstart + 3], 32'h303);
    @(posedge clk); #1;

    // rdy low for 3 cycles mid-read freezes address and delays completion by 3.
    setCh(1, 1'b0, 2'd2, 1'b0, 32'h100, 32'h0, 4'h8);
    ch_req[1] = 1'b1;
    waitGrant(1, ok);
    @(posedge clk); #1;
    checkOutput("stall_ram_a_pre", ram_a, 32'h101);
    rdy = 1'b0;
    @(posedge clk); #1;
    checkOutput("stall_ram_a_1", ram_a, 32'h101);
    @(posedge clk); #1;
    checkOutput("stall_ram_a_2", ram_a, 32'h101);
    checkOutput("stall_busy", 32'(busy), 32'd1);
    @(posedge clk); #1;
    rdy = 1'b1;
    waitRsp(cyc);
    checkOutput("stall_latency", 32'(cyc + 5), 32'd8);
    checkOutput("stall_data", rsp_data, 32'h4433_2211);
    checkOutput("stall_tag", 32'(rsp_tag), 32'h8);
    @(posedge clk); #1;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
